// File: rtl/fft_pkg.sv
// Shared constants, power type and frame-state enum for the FFT peak detector.
package fft_pkg;

    localparam int FFT_LEN_DEF = 1024;
    localparam int DW_DEF      = 25;

    typedef logic [2*DW_DEF:0] pwr_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } fsm_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fft_pwr_calc.sv
// Bin power re^2 + im^2 at full precision, with a tag carried alongside.
// Latency: 2 cycles (S1 squares, S2 sum).
// Backpressure: none; a beat presented with valid is always taken.
module fft_pwr_calc
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int TW = 8
) (
    input  logic            clk_100m,
    input  logic            rst,
    input  logic            valid,
    input  logic [DW-1:0]   re,
    input  logic [DW-1:0]   im,
    input  logic [TW-1:0]   tag,
    output logic            pwr_valid,
    output logic [2*DW:0]   pwr,
    output logic [TW-1:0]   pwr_tag
);

    logic signed [2*DW-1:0] re_x, im_x, sq_re, sq_im;
    logic                   s1_vld;
    logic [TW-1:0]          s1_tag;

    // Sign-extend first so the square of the most negative input still fits.
    assign re_x = {{DW{re[DW-1]}}, re};
    assign im_x = {{DW{im[DW-1]}}, im};

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            pwr_valid <= 1'b0;
        end else begin
            s1_vld    <= valid;
            pwr_valid <= s1_vld;
        end
    end

    always_ff @(posedge clk_100m) begin
        sq_re   <= re_x * re_x;
        sq_im   <= im_x * im_x;
        s1_tag  <= tag;
        pwr     <= {1'b0, sq_re} + {1'b0, sq_im};
        pwr_tag <= s1_tag;
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame maximum-power bin search over FFT output; PEAK_DC_SKIP_EN excludes bins 0 and FFT_LEN-1.
// Latency: 3 cycles from the eop beat to peak_valid / frame_err.
// Backpressure: none; every valid beat is consumed or discarded on arrival.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int DW      = DW_DEF
) (
    input  logic                      clk_100m,
    input  logic                      rst,
    input  logic                      data_sop,
    input  logic                      data_eop,
    input  logic                      data_valid,
    input  logic [DW-1:0]             data_real,
    input  logic [DW-1:0]             data_imag,
    input  logic [2*DW:0]             cfg_threshold,
    output logic                      peak_valid,
    output logic                      peak_found,
    output logic [clog2(FFT_LEN)-1:0] peak_bin,
    output logic [2*DW:0]             peak_pwr,
    output logic                      frame_err
);

    localparam int            BW       = clog2(FFT_LEN);
    localparam logic [BW-1:0] LAST_BIN = BW'(FFT_LEN - 1);

    typedef struct packed {
        logic [2*DW:0] thr;
        logic [BW-1:0] bin;
        logic          sop;
        logic          eop;
        logic          err;
    } tag_t;

    localparam int TW = $bits(tag_t);

    fsm_e          state, state_nxt;
    logic [BW-1:0] cnt, cnt_nxt, bin_inc;
    logic          in_vld, s0_vld, s2_vld;
    tag_t          in_tag, s0_tag, s2_tag;
    logic [DW-1:0] s0_re, s0_im;
    logic [2*DW:0] s2_pwr, max_pwr, cand_pwr, thr_q, thr_cur;
    logic [BW-1:0] max_bin, cand_bin;
    logic          seed, part, flush_done;

    assign bin_inc    = cnt + 1'b1;
    assign flush_done = s2_vld && s2_tag.eop;

    // FLUSH accepts a new sop exactly like IDLE, so back-to-back frames overlap it.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        in_vld     = 1'b0;
        in_tag     = '0;
        in_tag.thr = cfg_threshold;
        in_tag.bin = bin_inc;
        if (state == FLUSH && flush_done) state_nxt = IDLE;
        if (data_valid) begin
            if (data_sop) begin
                in_vld     = 1'b1;
                in_tag.bin = '0;
                in_tag.sop = 1'b1;
                in_tag.eop = data_eop;
                in_tag.err = (state == ACCUM) || (data_eop && FFT_LEN > 1);
                cnt_nxt    = '0;
                state_nxt  = data_eop ? FLUSH : ACCUM;
            end else if (state == ACCUM) begin
                in_vld = 1'b1;
                if (cnt == LAST_BIN) begin
                    // Beat past the last bin: only its error tag matters downstream.
                    in_tag.err = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt    = bin_inc;
                    in_tag.eop = data_eop;
                    in_tag.err = data_eop && (bin_inc != LAST_BIN);
                    if (data_eop) state_nxt = FLUSH;
                end
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            s0_vld <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            s0_vld <= in_vld;
        end
    end

    always_ff @(posedge clk_100m) begin
        s0_tag <= in_tag;
        s0_re  <= data_real;
        s0_im  <= data_imag;
    end

    fft_pwr_calc #(
        .DW (DW),
        .TW (TW)
    ) u_pwr_calc (
        .clk_100m  (clk_100m),
        .rst       (rst),
        .valid     (s0_vld),
        .re        (s0_re),
        .im        (s0_im),
        .tag       (s0_tag),
        .pwr_valid (s2_vld),
        .pwr       (s2_pwr),
        .pwr_tag   (s2_tag)
    );

`ifdef PEAK_DC_SKIP_EN
    assign seed = (s2_tag.bin == BW'(1));
    assign part = (s2_tag.bin != '0) && (s2_tag.bin != LAST_BIN);
`else
    assign seed = s2_tag.sop;
    assign part = 1'b1;
`endif

    // Strictly greater keeps the lowest index on ties.
    always_comb begin
        cand_pwr = max_pwr;
        cand_bin = max_bin;
        if (seed || (part && (s2_pwr > max_pwr))) begin
            cand_pwr = s2_pwr;
            cand_bin = s2_tag.bin;
        end
    end

    assign thr_cur = s2_tag.sop ? s2_tag.thr : thr_q;

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            peak_found <= 1'b0;
            peak_bin   <= '0;
            peak_pwr   <= '0;
            max_pwr    <= '0;
            max_bin    <= '0;
            thr_q      <= '0;
        end else begin
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (s2_vld) begin
                max_pwr <= cand_pwr;
                max_bin <= cand_bin;
                if (s2_tag.sop) thr_q <= s2_tag.thr;
                if (s2_tag.err) begin
                    frame_err <= 1'b1;
                end else if (s2_tag.eop) begin
                    peak_valid <= 1'b1;
                    peak_bin   <= cand_bin;
                    peak_pwr   <= cand_pwr;
                    peak_found <= (cand_pwr >= thr_cur);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: the driver queues expected results, a monitor checks them.
module tb_fft_peak_detect;
    import fft_pkg::*;

    localparam int N  = 1024;
    localparam int DW = 25;
    localparam int BW = 10;

`ifdef PEAK_DC_SKIP_EN
    localparam int   DC_BIN = 2;
    localparam pwr_t DC_PWR = 51'd10000;
`else
    localparam int   DC_BIN = 0;
    localparam pwr_t DC_PWR = 51'd25000000;
`endif

    logic          clk_100m = 1'b0;
    logic          rst = 1'b1;
    logic          data_sop = 1'b0;
    logic          data_eop = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_real = '0;
    logic [DW-1:0] data_imag = '0;
    pwr_t          cfg_threshold = '0;
    logic          peak_valid, peak_found, frame_err;
    logic [BW-1:0] peak_bin;
    pwr_t          peak_pwr;

    fft_peak_detect #(.FFT_LEN(N), .DW(DW)) dut (
        .clk_100m      (clk_100m),
        .rst           (rst),
        .data_sop      (data_sop),
        .data_eop      (data_eop),
        .data_valid    (data_valid),
        .data_real     (data_real),
        .data_imag     (data_imag),
        .cfg_threshold (cfg_threshold),
        .peak_valid    (peak_valid),
        .peak_found    (peak_found),
        .peak_bin      (peak_bin),
        .peak_pwr      (peak_pwr),
        .frame_err     (frame_err)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    typedef struct {
        int   kind;
        int   cyc;
        int   bin;
        pwr_t pwr;
        bit   found;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   last_cyc = 0;
    int   hold_bin = 0;
    pwr_t hold_pwr = '0;
    bit   hold_found = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic beat(input bit v, input bit s, input bit e, input int re, input int im, input bit r);
        @(negedge clk_100m);
        data_valid = v;
        data_sop   = s;
        data_eop   = e;
        data_real  = DW'(re);
        data_imag  = DW'(im);
        rst        = r;
        @(posedge clk_100m);
        #1;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // kind 1 = peak report, 2 = frame error; outputs expected are the held ones.
    task automatic push(input int kind);
        exp_t e;
        e.kind  = kind;
        e.cyc   = last_cyc + 3;
        e.bin   = hold_bin;
        e.pwr   = hold_pwr;
        e.found = hold_found;
        sb.push_back(e);
    endtask

    task automatic frame(input int n_beats, input int eop_at,
                         input int ba, input int ra, input int ia,
                         input int bb, input int rb, input int ib,
                         input pwr_t thr, input int err_at, input int rst_at,
                         input bit pk, input int e_bin, input pwr_t e_pwr, input bit e_found);
        int re;
        int im;
        cfg_threshold = thr;
        for (int i = 0; i < n_beats; i++) begin
            re = (i == ba) ? ra : ((i == bb) ? rb : 0);
            im = (i == ba) ? ia : ((i == bb) ? ib : 0);
            beat(1'b1, i == 0, i == eop_at, re, im, i == rst_at);
            if (i == err_at) push(2);
            if (i == eop_at && pk) begin
                hold_bin   = e_bin;
                hold_pwr   = e_pwr;
                hold_found = e_found;
                push(1);
            end
        end
    endtask

    always @(posedge clk_100m) begin
        #1;
        if (!rst && (peak_valid || frame_err)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_output: peak_valid=%0b frame_err=%0b at cycle %0d, nothing expected",
                         peak_valid, frame_err, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("kind", {62'b0, peak_valid, frame_err}, (mon_e.kind == 1) ? 64'd2 : 64'd1);
                chk("latency_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("peak_bin", 64'(peak_bin), 64'(mon_e.bin));
                chk("peak_pwr", 64'(peak_pwr), 64'(mon_e.pwr));
                chk("peak_found", 64'(peak_found), 64'(mon_e.found));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_100m);
        #1;
        chk("rst_peak_valid", 64'(peak_valid), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_peak_found", 64'(peak_found), 64'd0);
        chk("rst_peak_bin", 64'(peak_bin), 64'd0);
        chk("rst_peak_pwr", 64'(peak_pwr), 64'd0);
        idle(4);

        frame(N, N-1, 37, 1000, -1000, -1, 0, 0, 51'd1000, -1, -1, 1'b1, 37, 51'd2000000, 1'b1);
        idle(6);
        frame(N, N-1, 5, 300, 400, 900, 300, 400, 51'd0, -1, -1, 1'b1, 5, 51'd250000, 1'b1);
        idle(6);
        frame(N, N-1, 10, -16777216, -16777216, -1, 0, 0, 51'd1125899906842624, -1, -1,
              1'b1, 10, 51'd562949953421312, 1'b0);
        idle(6);
        // Early eop: error, earlier results stay on the outputs.
        frame(512, 511, 20, 9999, 0, -1, 0, 0, 51'd0, 511, -1, 1'b0, 0, '0, 1'b0);
        idle(6);
        // Back-to-back frames; second sop directly follows the first eop.
        frame(N, N-1, 3, 50, 0, -1, 0, 0, 51'd2500, -1, -1, 1'b1, 3, 51'd2500, 1'b1);
        frame(N, N-1, 700, 0, 70, -1, 0, 0, 51'd5000, -1, -1, 1'b1, 700, 51'd4900, 1'b0);
        idle(6);
        frame(N, N-1, 0, 5000, 0, 2, 100, 0, 51'd0, -1, -1, 1'b1, DC_BIN, DC_PWR, 1'b1);
        idle(6);

        // Reset at bin 400 discards the frame and clears the outputs.
        frame(N, N-1, 300, 800, 0, -1, 0, 0, 51'd0, -1, 400, 1'b0, 0, '0, 1'b0);
        idle(3);
        chk("midrst_peak_bin", 64'(peak_bin), 64'd0);
        chk("midrst_peak_pwr", 64'(peak_pwr), 64'd0);
        chk("midrst_peak_found", 64'(peak_found), 64'd0);
        hold_bin   = 0;
        hold_pwr   = '0;
        hold_found = 1'b0;

        // Abort: a new sop mid-frame errors the old one and starts a fresh frame.
        frame(100, -1, 50, 900, 900, -1, 0, 0, 51'd0, -1, -1, 1'b0, 0, '0, 1'b0);
        frame(N, N-1, 600, 7, 7, -1, 0, 0, 51'd98, 0, -1, 1'b1, 600, 51'd98, 1'b1);
        idle(6);

        // Overrun past the last bin, then stray beats that must be ignored.
        frame(N+1, -1, -1, 0, 0, -1, 0, 0, 51'd0, N, -1, 1'b0, 0, '0, 1'b0);
        beat(1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 5, 5, 1'b0);
        idle(6);

        // Single-beat frame (sop and eop together).
        frame(1, 0, 0, 3000, 0, -1, 0, 0, 51'd0, 0, -1, 1'b0, 0, '0, 1'b0);
        idle(6);

        // Beats without sop while idle produce nothing.
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, i == 4, 1234, 0, 1'b0);
        idle(6);

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
